// File: rtl/adder_sum_accumulator.sv
// Batch accumulator behind the BigAdder stage: sums COUNT 17-bit {carry,sum} samples
// (or fewer on flush) and holds the total on a valid/ready port until it is taken.
module adder_sum_accumulator #(
    parameter int DATA_W = 16,
    parameter int COUNT  = 8,
    parameter int ACC_W  = 20,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] sum_in,
    input  logic              carry_in,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  acc_out,
    output logic [CNT_W-1:0]  out_cnt,
    output logic              ovf
);

    typedef enum logic {ACCUM, HOLD} state_t;

    state_t             state;
    logic [ACC_W-1:0]   acc_p0;
    logic [CNT_W-1:0]   cnt_p0;
    logic               ovf_pend_p0;

    logic               accept;
    logic [ACC_W:0]     sum_ext;
    logic [ACC_W-1:0]   acc_next;
    logic [CNT_W-1:0]   cnt_next;
    logic               ovf_next;
    logic               close;

    // The carry input is the 17th sample bit, so the sample is DATA_W+1 wide before widening.
    function automatic logic [ACC_W:0] extend_sample(input logic c, input logic [DATA_W-1:0] s);
        return {{(ACC_W-DATA_W){1'b0}}, c, s};
    endfunction

    // One guard bit above the accumulator captures the wrap for the sticky overflow flag.
    function automatic logic [ACC_W:0] add_with_carry(input logic [ACC_W-1:0] a,
                                                      input logic [ACC_W:0]   b);
        return {1'b0, a} + b;
    endfunction

    assign in_ready = (state == ACCUM) && !rst;
    assign accept   = in_valid && in_ready;

    always_comb begin
        sum_ext  = add_with_carry(acc_p0, extend_sample(carry_in, sum_in));
        acc_next = acc_p0;
        cnt_next = cnt_p0;
        ovf_next = ovf_pend_p0;
        if (accept) begin
            acc_next = sum_ext[ACC_W-1:0];
            cnt_next = cnt_p0 + CNT_W'(1);
            ovf_next = ovf_pend_p0 | sum_ext[ACC_W];
        end
        // A lone flush on an empty batch has nothing to report and is dropped.
        close = (state == ACCUM) &&
                ((accept && (cnt_next == CNT_W'(COUNT))) ||
                 (flush && ((cnt_p0 != '0) || accept)));
    end

    // ---- stage p0: accumulate, then load the result registers on batch close ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ACCUM;
            acc_p0      <= '0;
            cnt_p0      <= '0;
            ovf_pend_p0 <= 1'b0;
            out_valid   <= 1'b0;
            acc_out     <= '0;
            out_cnt     <= '0;
            ovf         <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    acc_p0      <= acc_next;
                    cnt_p0      <= cnt_next;
                    ovf_pend_p0 <= ovf_next;
                    if (close) begin
                        state     <= HOLD;
                        out_valid <= 1'b1;
                        acc_out   <= acc_next;
                        out_cnt   <= cnt_next;
                        ovf       <= ovf_next;
                    end
                end
                HOLD: begin
                    // Result registers keep the old batch after the handshake.
                    if (out_valid && out_ready) begin
                        state       <= ACCUM;
                        out_valid   <= 1'b0;
                        acc_p0      <= '0;
                        cnt_p0      <= '0;
                        ovf_pend_p0 <= 1'b0;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule
